router_pkt_ctrl: RTL and testbench

Packet-level controller for the 1x3 router input path. It decodes the header address and waits for the selected destination FIFO to drain. It then sequences header, payload and parity loading into the input register and FIFOs, and stalls on FIFO-full. It sits between the input port and `router_reg`/`router_sync`, driving their load strobes and consuming their full, empty, soft-reset and parity-done status.

---
 rtl/router_pkg.sv | 42 ++++
 rtl/router_pkt_ctrl.sv | 98 +++++++++
 tb/tb_router_pkt_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared codes and widths for the 1x3 router input path.
// State encodings, header address codes and a per-destination status selector.
package router_pkg;

    localparam int unsigned HDR_ADDR_W = 2;

    localparam logic [HDR_ADDR_W-1:0] ADDR_0       = 2'b00;
    localparam logic [HDR_ADDR_W-1:0] ADDR_1       = 2'b01;
    localparam logic [HDR_ADDR_W-1:0] ADDR_2       = 2'b10;
    localparam logic [HDR_ADDR_W-1:0] ADDR_INVALID = 2'b11;

    localparam logic [2:0] ST_DECODE_ADDRESS     = 3'd0;
    localparam logic [2:0] ST_WAIT_TILL_EMPTY    = 3'd1;
    localparam logic [2:0] ST_LOAD_FIRST_DATA    = 3'd2;
    localparam logic [2:0] ST_LOAD_DATA          = 3'd3;
    localparam logic [2:0] ST_FIFO_FULL_STATE    = 3'd4;
    localparam logic [2:0] ST_LOAD_AFTER_FULL    = 3'd5;
    localparam logic [2:0] ST_LOAD_PARITY        = 3'd6;
    localparam logic [2:0] ST_CHECK_PARITY_ERROR = 3'd7;

    typedef enum logic [2:0] {
        DecodeAddress    = ST_DECODE_ADDRESS,
        WaitTillEmpty    = ST_WAIT_TILL_EMPTY,
        LoadFirstData    = ST_LOAD_FIRST_DATA,
        LoadData         = ST_LOAD_DATA,
        FifoFullState    = ST_FIFO_FULL_STATE,
        LoadAfterFull    = ST_LOAD_AFTER_FULL,
        LoadParity       = ST_LOAD_PARITY,
        CheckParityError = ST_CHECK_PARITY_ERROR
    } state_e;

    // Picks the status bit of one FIFO; the invalid address selects nothing.
    function automatic logic sel_fifo(input logic [2:0] v, input logic [HDR_ADDR_W-1:0] a);
        case (a)
            ADDR_0:  sel_fifo = v[0];
            ADDR_1:  sel_fifo = v[1];
            ADDR_2:  sel_fifo = v[2];
            default: sel_fifo = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/router_pkt_ctrl.sv
// Packet-level FSM for the router input path: header decode, drain wait,
// payload/parity load sequencing and full-FIFO stall handling.
module router_pkt_ctrl
    import router_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pkt_valid,
    input  logic [HDR_ADDR_W-1:0] data_in,
    input  logic                  fifo_full,
    input  logic                  fifo_empty_0,
    input  logic                  fifo_empty_1,
    input  logic                  fifo_empty_2,
    input  logic                  soft_rst_0,
    input  logic                  soft_rst_1,
    input  logic                  soft_rst_2,
    input  logic                  parity_done,
    input  logic                  low_pkt_valid,
    output logic                  detect_add,
    output logic                  lfd_state,
    output logic                  ld_state,
    output logic                  laf_state,
    output logic                  full_state,
    output logic                  write_enb_reg,
    output logic                  rst_int_reg,
    output logic                  busy
);

    state_e                state_q, state_d;
    logic [HDR_ADDR_W-1:0] dest_q, dest_d;
    logic [2:0]            empty_vec, soft_vec;
    logic                  hdr_ok, empty_hdr, empty_d, soft_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DecodeAddress;
            dest_q  <= ADDR_0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
        end
    end

    always_comb begin
        empty_vec = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
        soft_vec  = {soft_rst_2, soft_rst_1, soft_rst_0};
        hdr_ok    = pkt_valid && (data_in != ADDR_INVALID);
        // The header byte is still on data_in during decode, so use it directly.
        empty_hdr = sel_fifo(empty_vec, data_in);
        empty_d   = sel_fifo(empty_vec, dest_q);
        soft_d    = sel_fifo(soft_vec, dest_q);

        dest_d = dest_q;
        if (state_q == DecodeAddress && hdr_ok) begin
            dest_d = data_in;
        end

        state_d = state_q;
        case (state_q)
            DecodeAddress: begin
                if (hdr_ok) state_d = empty_hdr ? LoadFirstData : WaitTillEmpty;
            end
            WaitTillEmpty: if (empty_d) state_d = LoadFirstData;
            LoadFirstData: state_d = LoadData;
            LoadData: begin
                if (fifo_full)      state_d = FifoFullState;
                else if (!pkt_valid) state_d = LoadParity;
            end
            FifoFullState: if (!fifo_full) state_d = LoadAfterFull;
            LoadAfterFull: begin
                if (parity_done)        state_d = DecodeAddress;
                else if (low_pkt_valid) state_d = LoadParity;
                else                    state_d = LoadData;
            end
            LoadParity:       state_d = CheckParityError;
            CheckParityError: state_d = fifo_full ? FifoFullState : DecodeAddress;
            default:          state_d = DecodeAddress;
        endcase

        // A timed-out destination FIFO abandons the packet from any state.
        if (state_q != DecodeAddress && soft_d) begin
            state_d = DecodeAddress;
        end
    end

    always_comb begin
        detect_add    = (state_q == DecodeAddress);
        lfd_state     = (state_q == LoadFirstData);
        ld_state      = (state_q == LoadData);
        laf_state     = (state_q == LoadAfterFull);
        full_state    = (state_q == FifoFullState);
        write_enb_reg = (state_q == LoadData) || (state_q == LoadAfterFull) ||
                        (state_q == LoadParity);
        rst_int_reg   = (state_q == CheckParityError);
        busy          = (state_q != DecodeAddress) && (state_q != LoadData);
    end

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// Directed bench for router_pkt_ctrl: expected output vectors are queued per
// clock by the stimulus and popped/compared by an independent monitor.
module tb_router_pkt_ctrl;

    // Output vector order: detect_add, lfd, ld, laf, full, write_enb, rst_int, busy
    localparam logic [7:0] E_DA  = 8'b1000_0000;
    localparam logic [7:0] E_WTE = 8'b0000_0001;
    localparam logic [7:0] E_LFD = 8'b0100_0001;
    localparam logic [7:0] E_LD  = 8'b0010_0100;
    localparam logic [7:0] E_FF  = 8'b0000_1001;
    localparam logic [7:0] E_LAF = 8'b0001_0101;
    localparam logic [7:0] E_LP  = 8'b0000_0101;
    localparam logic [7:0] E_CPE = 8'b0000_0011;

    typedef struct {
        logic [7:0] v;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       pkt_valid, fifo_full, parity_done, low_pkt_valid;
    logic [1:0] data_in;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_rst_0, soft_rst_1, soft_rst_2;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, busy;
    logic [7:0] outv;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    router_pkt_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .pkt_valid    (pkt_valid),
        .data_in      (data_in),
        .fifo_full    (fifo_full),
        .fifo_empty_0 (fifo_empty_0),
        .fifo_empty_1 (fifo_empty_1),
        .fifo_empty_2 (fifo_empty_2),
        .soft_rst_0   (soft_rst_0),
        .soft_rst_1   (soft_rst_1),
        .soft_rst_2   (soft_rst_2),
        .parity_done  (parity_done),
        .low_pkt_valid(low_pkt_valid),
        .detect_add   (detect_add),
        .lfd_state    (lfd_state),
        .ld_state     (ld_state),
        .laf_state    (laf_state),
        .full_state   (full_state),
        .write_enb_reg(write_enb_reg),
        .rst_int_reg  (rst_int_reg),
        .busy         (busy)
    );

    assign outv = {detect_add, lfd_state, ld_state, laf_state, full_state,
                   write_enb_reg, rst_int_reg, busy};

    // Monitor: the DUT presents a new Moore output every cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (outv !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b at %0t", e.name, outv, e.v, $time);
            end
        end
    end

    // Advance one clock with the inputs currently driven and queue the expectation.
    task automatic cyc(input logic [7:0] v, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        e.v    = v;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic direct_check(input logic [7:0] v, input string name);
        n_checks++;
        if (outv !== v) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, outv, v, $time);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        pkt_valid = 0; data_in = 2'b00; fifo_full = 0; parity_done = 0; low_pkt_valid = 0;
        fifo_empty_0 = 1; fifo_empty_1 = 1; fifo_empty_2 = 1;
        soft_rst_0 = 0; soft_rst_1 = 0; soft_rst_2 = 0;
        #12;
        direct_check(E_DA, "reset_state");
        @(negedge clk);
        rst = 1'b1;
        cyc(E_DA, "idle_after_reset");

        // Header to FIFO 1 (empty), two payload bytes, then parity.
        pkt_valid = 1; data_in = 2'b01;
        cyc(E_LFD, "p1_lfd");
        data_in = 2'b10;
        cyc(E_LD, "p1_ld0");
        cyc(E_LD, "p1_ld1");
        pkt_valid = 0;
        cyc(E_LP, "p1_parity_load");
        cyc(E_CPE, "p1_check_parity");
        cyc(E_DA, "p1_back_to_decode");

        // Header to FIFO 2 while it still drains for 5 cycles.
        fifo_empty_2 = 0; pkt_valid = 1; data_in = 2'b10;
        for (int i = 0; i < 5; i++) cyc(E_WTE, "p2_wait_empty");
        fifo_empty_2 = 1;
        cyc(E_LFD, "p2_lfd_after_drain");
        cyc(E_LD, "p2_ld");

        // Full for 3 cycles, then replay and back to streaming.
        fifo_full = 1;
        for (int i = 0; i < 3; i++) cyc(E_FF, "p2_full_stall");
        fifo_full = 0;
        cyc(E_LAF, "p2_laf");
        cyc(E_LD, "p2_ld_resume");

        // Full and pkt_valid falling together: full wins; then low_pkt_valid path.
        fifo_full = 1; pkt_valid = 0;
        cyc(E_FF, "p2_full_beats_parity");
        fifo_full = 0; low_pkt_valid = 1;
        cyc(E_LAF, "p2_laf_low");
        cyc(E_LP, "p2_parity_after_laf");
        low_pkt_valid = 0;
        cyc(E_CPE, "p2_check_parity");
        cyc(E_DA, "p2_done");

        // Full during parity check, then parity_done ends the packet from LAF.
        pkt_valid = 1; data_in = 2'b01;
        cyc(E_LFD, "p3_lfd");
        cyc(E_LD, "p3_ld");
        pkt_valid = 0;
        cyc(E_LP, "p3_parity_load");
        fifo_full = 1;
        cyc(E_CPE, "p3_check_parity");
        cyc(E_FF, "p3_full_after_check");
        fifo_full = 0;
        cyc(E_LAF, "p3_laf");
        parity_done = 1;
        cyc(E_DA, "p3_parity_done_exit");
        parity_done = 0;

        // Destination 0 waiting: foreign soft reset ignored, own soft reset aborts.
        fifo_empty_0 = 0; pkt_valid = 1; data_in = 2'b00;
        cyc(E_WTE, "p4_wait");
        soft_rst_1 = 1;
        cyc(E_WTE, "p4_soft_rst_other_ignored");
        soft_rst_1 = 0;
        cyc(E_WTE, "p4_still_waiting");
        soft_rst_0 = 1;
        cyc(E_DA, "p4_soft_rst_abort");
        soft_rst_0 = 0; pkt_valid = 0; fifo_empty_0 = 1;
        cyc(E_DA, "p4_idle");

        // Invalid address is not accepted.
        pkt_valid = 1; data_in = 2'b11;
        cyc(E_DA, "invalid_addr_0");
        cyc(E_DA, "invalid_addr_1");

        // Asynchronous reset mid-payload.
        data_in = 2'b01;
        cyc(E_LFD, "p5_lfd");
        cyc(E_LD, "p5_ld");
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        direct_check(E_DA, "async_reset_mid_packet");
        cyc(E_DA, "held_in_reset");
        @(negedge clk);
        rst = 1'b1; pkt_valid = 0;
        cyc(E_DA, "idle_after_second_reset");

        repeat (2) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
